// File: rtl/latch_bank_write_scheduler_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// latch_sched_pkg : scheduler state type, default sizes, latch-enable decode
// Rev 1.0
// ----------------------------------------------------------------------------
package latch_sched_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } sched_state_t;

  localparam int DEF_N_REQ  = 4;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_DATA_W = 8;

  function automatic logic addr_in_range(input int addr, input int depth);
    return addr < depth;
  endfunction

  // One bit of the one-hot latch enable; an out-of-range address enables nothing.
  function automatic logic latch_en_bit(input int addr, input int idx, input int depth);
    return addr_in_range(addr, depth) && (addr == idx);
  endfunction

endpackage
`default_nettype wire

// File: rtl/latch_bank_write_scheduler_rr_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// rr_arbiter : combinational round-robin pick, search starts just after ptr
// Rev 1.0
// ----------------------------------------------------------------------------
module rr_arbiter
  import latch_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ-1:0]         mask,
  input  logic [$clog2(N_REQ)-1:0] ptr,
  output logic                     gnt_valid,
  output logic [$clog2(N_REQ)-1:0] gnt_idx
);

  localparam int IW = $clog2(N_REQ);

  logic [N_REQ-1:0] eligible;
  logic [IW-1:0]    cand;

  assign eligible = req & ~mask;

  // Walk from the farthest slot to the nearest so the nearest eligible one wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = IW'((int'(ptr) + k) % N_REQ);
      if (eligible[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/latch_bank_write_scheduler.sv
`default_nettype none
// ----------------------------------------------------------------------------
// latch_bank_write_scheduler : shares a latch bank between writers, setup/strobe/hold
// Rev 1.0
// ----------------------------------------------------------------------------
module latch_bank_write_scheduler
  import latch_sched_pkg::*;
#(
  parameter  int N_REQ  = DEF_N_REQ,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int DATA_W = DEF_DATA_W,
  localparam int AW     = $clog2(DEPTH),
  localparam int IW     = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*AW-1:0]     req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    req_err,
  output logic [DEPTH-1:0]        st_en,
  output logic [DATA_W-1:0]       st_d,
  output logic                    busy,
  output logic [IW-1:0]           last_grant
);

  sched_state_t      state;
  logic [AW-1:0]     cap_addr;
  logic [N_REQ-1:0]  hold_mask;
  logic              gnt_valid;
  logic [IW-1:0]     gnt_idx;
  logic [AW-1:0]     sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [DEPTH-1:0]  en_dec;
  logic              cap_oor;

  // The requester finishing in HOLD still shows its old valid; keep it out of the pick.
  always_comb begin
    hold_mask = '0;
    if (state == HOLD) begin
      hold_mask[last_grant] = 1'b1;
    end
  end

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req      (req_valid),
    .mask     (hold_mask),
    .ptr      (last_grant),
    .gnt_valid(gnt_valid),
    .gnt_idx  (gnt_idx)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        sel_addr = req_addr[i*AW +: AW];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    en_dec = '0;
    for (int j = 0; j < DEPTH; j++) begin
      en_dec[j] = latch_en_bit(int'(cap_addr), j, DEPTH);
    end
  end

  assign cap_oor = !addr_in_range(int'(cap_addr), DEPTH);

  // st_d doubles as the captured data register: it only moves on a grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cap_addr   <= '0;
      st_d       <= '0;
      st_en      <= '0;
      req_ready  <= '0;
      req_err    <= 1'b0;
      busy       <= 1'b0;
      last_grant <= IW'(N_REQ - 1);
    end else begin
      st_en     <= '0;
      req_ready <= '0;
      req_err   <= 1'b0;
      case (state)
        IDLE, HOLD: begin
          if (gnt_valid) begin
            state      <= SETUP;
            busy       <= 1'b1;
            last_grant <= gnt_idx;
            cap_addr   <= sel_addr;
            st_d       <= sel_data;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        SETUP: begin
          state <= STROBE;
          st_en <= en_dec;
        end
        STROBE: begin
          state                 <= HOLD;
          req_ready[last_grant] <= 1'b1;
          req_err               <= cap_oor;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
